nibble_fifo: RTL and testbench
==============================

Name: nibble_fifo

Overview:
- Downstream consumer of the 4-bit registered datapath. Buffers the registered nibble stream in a small synchronous FIFO and presents it to the next stage over a valid/ready handshake.
- Decouples the free-running register, which updates every cycle, from a consumer that may stall.
- Single clock domain, show-ahead (first-word-fall-through) output.

Parameters:
- WIDTH, 4, data width in bits; matches the upstream register width.
- DEPTH, 4, number of entries; must be a power of two and ≥ 2.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_data  input  WIDTH  nibble from the upstream register output
- in_valid  input  1  in_data is valid this cycle
- in_ready  output  1  FIFO can accept a word this cycle
- out_data  output  WIDTH  head-of-queue word
- out_valid  output  1  out_data is valid
- out_ready  input  1  consumer takes out_data this cycle
- count  output  $clog2(DEPTH)+1  number of stored entries, 0..DEPTH
- full  output  1  count == DEPTH
- empty  output  1  count == 0

Behaviour:
- Interface decision: one clock (clk); reset is synchronous, active-high (reset), sampled on the rising edge of clk.
- Reset state, visible after the first clk edge with reset=1:
  - wr_ptr = rd_ptr = 0, count = 0
  - empty = 1, full = 0, in_ready = 1, out_valid = 0, out_data = 0
  - storage array is not reset.
- Handshake events:
  - push = in_valid && in_ready
  - pop = out_valid && out_ready
- Combinational status:
  - in_ready = !full
  - out_valid = !empty
  - full and empty decode from count.
- out_data = mem[rd_ptr] when !empty; forced to 0 when empty.
- Push: mem[wr_ptr] <= in_data; wr_ptr increments modulo DEPTH.
- Pop: rd_ptr increments modulo DEPTH.
- Count update: push only → count+1; pop only → count−1; both or neither → unchanged.
- Latency: a word pushed at edge N is visible on out_data with out_valid=1 immediately after edge N (1-cycle write-to-read). No combinational in→out path.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally; no other wrap logic.
- Boundary: empty with in_valid=1 and out_ready=1:
  - push only (out_valid=0, so no pop).
  - word appears next cycle; count becomes 1.
- Boundary: full with in_valid=1:
  - in_ready=0, so the word is not accepted and the upstream must hold it.
  - a simultaneous pop still occurs; count becomes DEPTH−1.
  - no pass-through when full.
- Boundary: count = DEPTH−1 with push and pop in the same cycle → count unchanged, full stays 0.
- Handshake rules:
  - in_valid must not depend on in_ready.
  - out_valid never drops without a pop, except on reset.
- Reset mid-operation: all contents discarded; outputs return to the reset state on that edge; a push or pop in the reset cycle is ignored.
- Illegal conditions, flagged by assertions rather than handled in RTL:
  - count > DEPTH
  - full && empty

Decomposition:
- Package nibble_pkg holds:
  - NIBBLE_W = 4
  - typedef logic [NIBBLE_W-1:0] nibble_t
  - FIFO_DEPTH = 4
- Shared with the upstream register block.
- Sub-module fifo_ptr: a modulo-DEPTH pointer counter with synchronous reset and an increment enable, instantiated twice (write and read).
- Storage, count and status flags stay in nibble_fifo.
- COCOTB_SIM guard dumps a VCD of all ports (wave_sv.vcd).

Test Plan:
1. Reset: assert reset 2 cycles → count=0, empty=1, full=0, in_ready=1, out_valid=0, out_data=0.
2. Fill/drain: out_ready=0, push 0x1, 0x2, 0x3, 0x4 → full=1, in_ready=0, count=4. Then out_ready=1 for 4 cycles → out_data reads 0x1, 0x2, 0x3, 0x4 in order; ends with empty=1.
3. Overflow hold: when full, drive in_valid=1 with 0xF and out_ready=0 for 3 cycles → count stays 4, 0xF never appears. Then a single pop → count=3; 0xF is accepted only on the next cycle.
4. Simultaneous push/pop at count=2 for 10 cycles with an incrementing stream 0x0..0x9 → count stays 2, outputs in order, pointers wrap past 3→0 correctly.
5. Empty push+pop: count=0, in_valid=1 with 0xA, out_ready=1 → no pop that cycle; next cycle out_valid=1 with out_data=0xA; popped on the following edge.
6. Reset mid-stream: count=3, assert reset for 1 cycle with in_valid=1 → count=0, empty=1, and no old data appears afterwards.

Source files
------------

// File: rtl/nibble_pkg.sv
// Shared nibble datapath types and sizing for the register block and its consumers.
package nibble_pkg;

  localparam int NIBBLE_W   = 4;
  localparam int FIFO_DEPTH = 4;

  typedef logic [NIBBLE_W-1:0] nibble_t;

endpackage

// File: rtl/fifo_ptr.sv
// Modulo-DEPTH pointer: advances by one when inc is high, wraps through its natural width.
// Latency: new value visible after the edge; no backpressure, inc is a plain enable.
module fifo_ptr #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  output logic [AW-1:0] ptr
);

  logic [AW-1:0] ptr_q;
  logic [AW-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (inc) ptr_d = ptr_q + AW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/nibble_fifo.sv
// Show-ahead nibble FIFO: a word pushed at one edge is on out_data right after it.
// Backpressure: in_ready drops while full, and a pop in that cycle does not let a push through.
module nibble_fifo
  import nibble_pkg::*;
#(
  parameter int WIDTH = NIBBLE_W,
  parameter int DEPTH = FIFO_DEPTH,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count     = count_q;
  assign out_data  = empty ? '0 : mem_q[rd_ptr];

  fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (push),
    .ptr   (wr_ptr)
  );

  fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (pop),
    .ptr   (rd_ptr)
  );

  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr] = in_data;
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage is deliberately left out of reset; count gates its visibility.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  a_count_range : assert property (@(posedge clk) disable iff (reset) count_q <= CW'(DEPTH));
  a_full_empty  : assert property (@(posedge clk) disable iff (reset) !(full && empty));

endmodule

// File: tb/tb_nibble_fifo.sv
// Scoreboard bench for nibble_fifo: a queue model tracks accepted words and status.
module tb_nibble_fifo;
  import nibble_pkg::*;

  localparam int DEPTH = FIFO_DEPTH;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          reset;
  nibble_t       in_data;
  logic          in_valid;
  logic          in_ready;
  nibble_t       out_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;

  int n_checks = 0;
  int n_fails  = 0;

  nibble_t exp_q[$];

  nibble_fifo #(.WIDTH(NIBBLE_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Monitor: inputs change just after posedge, so the negedge sees the state
  // and inputs that the next rising edge will act on.
  always @(negedge clk) begin
    int  sz;
    bit  will_pop;
    bit  will_push;
    if (reset) begin
      exp_q.delete();
    end else begin
      sz = exp_q.size();
      chk("count",     int'(count),     sz);
      chk("full",      int'(full),      int'(sz == DEPTH));
      chk("empty",     int'(empty),     int'(sz == 0));
      chk("in_ready",  int'(in_ready),  int'(sz < DEPTH));
      chk("out_valid", int'(out_valid), int'(sz > 0));
      chk("out_data",  int'(out_data),  (sz > 0) ? int'(exp_q[0]) : 0);
      will_pop  = (sz > 0) && out_ready;
      will_push = in_valid && (sz < DEPTH);
      if (will_pop)  void'(exp_q.pop_front());
      if (will_push) exp_q.push_back(in_data);
    end
  end

  task automatic cyc(input logic v, input nibble_t d, input logic r, input logic rst = 1'b0);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    reset     = rst;
    @(posedge clk);
    #1;
  endtask

  initial begin
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    reset     = 1'b1;

    // Reset for two cycles
    cyc(1'b0, 4'h0, 1'b0, 1'b1);
    cyc(1'b0, 4'h0, 1'b0, 1'b1);

    // Fill then drain
    for (int i = 1; i <= 4; i++) cyc(1'b1, nibble_t'(i), 1'b0);
    for (int i = 0; i < 4; i++)  cyc(1'b0, 4'h0, 1'b1);
    cyc(1'b0, 4'h0, 1'b0);

    // Overflow hold: 0xF offered while full
    for (int i = 5; i <= 8; i++) cyc(1'b1, nibble_t'(i), 1'b0);
    for (int i = 0; i < 3; i++)  cyc(1'b1, 4'hF, 1'b0);
    cyc(1'b1, 4'hF, 1'b1);
    cyc(1'b1, 4'hF, 1'b0);
    for (int i = 0; i < 5; i++)  cyc(1'b0, 4'h0, 1'b1);

    // Steady push+pop at count 2 across pointer wrap
    cyc(1'b1, 4'hC, 1'b0);
    cyc(1'b1, 4'hD, 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b1, nibble_t'(i), 1'b1);
    for (int i = 0; i < 3; i++)  cyc(1'b0, 4'h0, 1'b1);

    // Push into empty with out_ready high
    cyc(1'b1, 4'hA, 1'b1);
    cyc(1'b0, 4'h0, 1'b1);
    cyc(1'b0, 4'h0, 1'b1);

    // Reset with three words stored and a push offered
    for (int i = 0; i < 3; i++) cyc(1'b1, nibble_t'(4'h6 + i), 1'b0);
    cyc(1'b1, 4'hE, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 4'h0, 1'b1);
    cyc(1'b1, 4'h3, 1'b0);
    cyc(1'b0, 4'h0, 1'b1);
    cyc(1'b0, 4'h0, 1'b1);

    // Random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 1)), nibble_t'($urandom_range(0, 15)),
          1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 60) == 0));
    end
    for (int i = 0; i < 6; i++) cyc(1'b0, 4'h0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
